// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer
//   Drives the parallel DAC interface: a startup SYNC pulse, one all-zero
//   alignment frame, then a continuous sample stream with a FRAME marker on
//   word 0 of every frame. Stream data arrives over ready/valid. A missing
//   sample is replaced by zero and flagged as a sticky underflow. Stop
//   requests only take effect on frame boundaries.
//
//   Optional macro DAC_FRAME_SEQUENCER_PARITY_EN:
//     defined   -> dac_parity is the even parity of dac_d, registered
//                  alongside it.
//     undefined -> no parity logic is built and dac_parity is held at 0.
//
// Ports
//   clk            system clock (FPGA0_CLK domain)
//   rst            asynchronous, active-high reset
//   enable         level: 1 requests streaming, 0 requests stop
//   s_data/s_valid sample stream input (two's-complement)
//   s_ready        sequencer accepts s_data this cycle (high in RUN)
//   dac_d          registered DAC data word
//   dac_frame      high on word 0 of each frame
//   dac_sync       DAC sync strobe, high for SYNC_CYCLES during startup
//   dac_parity     even parity over dac_d (0 when the macro is undefined)
//   running        high while streaming
//   underflow      sticky flag, set on any RUN cycle without s_valid
//   underflow_clr  clears underflow (a simultaneous set wins)
module dac_frame_sequencer #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int SYNC_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] dac_d,
    output logic        dac_frame,
    output logic        dac_sync,
    output logic        dac_parity,
    output logic        running,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int SCW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, ALIGN, RUN} state_t;

    state_t         state, state_nxt;
    logic [SCW-1:0] sync_cnt;
    logic [WCW-1:0] word_cnt;
    logic           sync_done, frame_end, in_run;
    logic [15:0]    d_nxt;

    assign sync_done = (sync_cnt == SYNC_LAST);
    assign frame_end = (word_cnt == WORD_LAST);
    assign in_run    = (state == RUN);

    // Status outputs decode the state register directly, so they drop
    // together with the state on an asynchronous reset.
    assign s_ready  = in_run;
    assign running  = in_run;
    assign dac_sync = (state == SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable) state_nxt = SYNC;
            SYNC:  if (!enable) state_nxt = IDLE;
                   else if (sync_done) state_nxt = ALIGN;
            ALIGN: if (!enable) state_nxt = IDLE;
                   else if (frame_end) state_nxt = RUN;
            // Stop is only honoured on the last word of a frame; raising
            // enable again before then simply keeps streaming.
            RUN:   if (!enable && frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The word counter runs through ALIGN and carries into RUN, so the
    // wrap at the end of the alignment frame lands RUN on word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (state == SYNC && state_nxt == SYNC) sync_cnt <= sync_cnt + 1'b1;
            else                                   sync_cnt <= '0;

            if ((state == ALIGN || state == RUN) &&
                (state_nxt == ALIGN || state_nxt == RUN))
                word_cnt <= frame_end ? '0 : word_cnt + 1'b1;
            else
                word_cnt <= '0;
        end
    end

    // Only RUN passes sample data; every other state (and an empty RUN
    // slot) emits zero.
    assign d_nxt = (in_run && s_valid) ? s_data : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_d     <= 16'h0000;
            dac_frame <= 1'b0;
            underflow <= 1'b0;
        end else begin
            dac_d <= d_nxt;
            // Frame marker: word 0 of the alignment frame, or word 0 of
            // any streamed frame.
            dac_frame <= (in_run && word_cnt == '0) ||
                         (state == SYNC && state_nxt == ALIGN);
            if (in_run && !s_valid) underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end

`ifdef DAC_FRAME_SEQUENCER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dac_parity <= 1'b0;
        else     dac_parity <= ^d_nxt;
    end
`else
    assign dac_parity = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer (WORDS_PER_FRAME=4, SYNC_CYCLES=16).
// A model based on elapsed time since the start request predicts every
// output on every cycle. Directed vectors pin startup length, frame
// cadence, underflow, stop, abort and reset with literal expectations.
module tb_dac_frame_sequencer;

    localparam int W = 4;
    localparam int S = 16;

    logic        clk, rst, enable, s_valid, underflow_clr;
    logic [15:0] s_data;
    logic        s_ready, dac_frame, dac_sync, dac_parity, running, underflow;
    logic [15:0] dac_d;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    dac_frame_sequencer #(.WORDS_PER_FRAME(W), .SYNC_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .dac_d(dac_d),
        .dac_frame(dac_frame), .dac_sync(dac_sync), .dac_parity(dac_parity),
        .running(running), .underflow(underflow), .underflow_clr(underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: 'act' means a start request is in progress; 'el' counts cycles
    // since it began. First S cycles are sync, next W align, then streaming.
    bit          act   = 0;
    int          el    = 0;
    logic [15:0] m_d   = 0;
    bit          m_f   = 0;
    bit          m_und = 0;
    bit          pre_run, nact;
    int          slot, nel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act = 0; el = 0; m_d = 0; m_f = 0; m_und = 0;
        end else begin
            pre_run = act && (el >= S + W);
            slot    = pre_run ? (el - (S + W)) % W : 0;
            m_d     = (pre_run && s_valid) ? s_data : 16'h0000;
            if (pre_run && !s_valid) m_und = 1;
            else if (underflow_clr)  m_und = 0;
            if (!act) begin
                nact = enable; nel = 0;
            end else if (!pre_run) begin
                nact = enable; nel = el + 1;
            end else begin
                nact = enable || (slot != W - 1); nel = el + 1;
            end
            if (!nact) nel = 0;
            m_f = (pre_run && slot == 0) || (nact && nel == S);
            act = nact; el = nel;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_dac_d",     dac_d,     m_d);
            chk("m_dac_frame", dac_frame, m_f);
            chk("m_dac_sync",  dac_sync,  act && el < S);
            chk("m_s_ready",   s_ready,   act && el >= S + W);
            chk("m_running",   running,   act && el >= S + W);
            chk("m_underflow", underflow, m_und);
`ifdef DAC_FRAME_SEQUENCER_PARITY_EN
            chk("m_parity",    dac_parity, ^m_d);
`else
            chk("m_parity",    dac_parity, 1'b0);
`endif
        end
    end

    // Raises enable and walks through startup, recording how long sync is
    // high, when the first frame marker appears and when s_ready rises.
    task automatic startup(output int sh, output int fk, output int rk);
        enable = 1;
        sh = 0; fk = -1; rk = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (dac_sync) sh++;
            if (dac_frame && fk < 0) fk = k;
            if (s_ready) begin rk = k; break; end
        end
    endtask

    task automatic drive(input logic [15:0] d);
        s_valid = 1; s_data = d;
        @(negedge clk);
    endtask

    logic [15:0] got_d [1:12];
    logic        got_f [1:12];
    logic        got_p [1:12];
    int sh, fk, rk;

    initial begin
        rst = 1; enable = 0; s_valid = 0; s_data = 0; underflow_clr = 0;
        @(posedge clk);
        armed = 1;
        repeat (2) @(negedge clk);
        chk("rst_dac_d",   dac_d, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_sync",    dac_sync, 0);
        chk("rst_under",   underflow, 0);
        rst = 0;
        @(negedge clk);

        // Startup
        startup(sh, fk, rk);
        chk("sync_len", sh, 16);
        chk("align_frame_k", fk, 17);
        chk("ready_k", rk, 21);
        chk("running_up", running, 1);

        // Streaming 1..12
        for (int j = 1; j <= 12; j++) begin
            drive(16'(j));
            got_d[j] = dac_d; got_f[j] = dac_frame; got_p[j] = dac_parity;
        end
        chk("d1", got_d[1], 16'h0001);
        chk("d7", got_d[7], 16'h0007);
        chk("d12", got_d[12], 16'h000c);
        chk("f1", got_f[1], 1);
        chk("f2", got_f[2], 0);
        chk("f4", got_f[4], 0);
        chk("f5", got_f[5], 1);
        chk("f9", got_f[9], 1);
`ifdef DAC_FRAME_SEQUENCER_PARITY_EN
        chk("p1", got_p[1], 1);
        chk("p3", got_p[3], 0);
`else
        chk("p1_off", got_p[1], 0);
        chk("p7_off", got_p[7], 0);
`endif
        chk("under_clean", underflow, 0);

        // Underflow in slot 2
        drive(16'd13);
        drive(16'd14);
        s_valid = 0; s_data = 16'hbeef;
        @(negedge clk);
        chk("gap_d", dac_d, 0);
        chk("gap_under", underflow, 1);
        drive(16'd16);
        chk("gap_f3", dac_frame, 0);
        underflow_clr = 1;
        drive(16'd17);
        chk("cadence_f0", dac_frame, 1);
        chk("clr_under", underflow, 0);
        s_valid = 0;
        @(negedge clk);
        chk("set_wins", underflow, 1);
        underflow_clr = 0;
        drive(16'd19);
        drive(16'd20);
        chk("sticky", underflow, 1);

        // Stop requested while slot 1 is accepted
        drive(16'd21);
        enable = 0;
        drive(16'd22);
        drive(16'd23);
        chk("stop_still_ready", s_ready, 1);
        drive(16'd24);
        chk("stop_last_d", dac_d, 16'd24);
        chk("stop_ready", s_ready, 0);
        chk("stop_running", running, 0);
        s_valid = 0;
        @(negedge clk);
        chk("idle_d", dac_d, 0);

        // Abort after 5 sync cycles
        enable = 1;
        repeat (5) @(negedge clk);
        chk("abort_sync_on", dac_sync, 1);
        enable = 0;
        @(negedge clk);
        chk("abort_sync_off", dac_sync, 0);
        @(negedge clk);
        chk("abort_idle", s_ready, 0);

        // Full restart
        startup(sh, fk, rk);
        chk("re_sync_len", sh, 16);
        chk("re_frame_k", fk, 17);
        chk("re_ready_k", rk, 21);

        // Mid-RUN reset with underflow set and an odd-parity word in flight
        s_valid = 0;
        @(negedge clk);
        chk("pre_rst_under", underflow, 1);
        drive(16'h0007);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("mrst_d", dac_d, 0);
        chk("mrst_ready", s_ready, 0);
        chk("mrst_running", running, 0);
        chk("mrst_under", underflow, 0);
        chk("mrst_parity", dac_parity, 0);
        chk("mrst_frame", dac_frame, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        s_valid = 1;
        startup(sh, fk, rk);
        chk("post_rst_sync", sh, 16);
        chk("post_rst_ready_k", rk, 21);
        s_valid = 0;
        enable = 0;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_frame_sequencer.md
Name: dac_frame_sequencer

Overview:
- Sequences the parallel DAC interface: startup SYNC pulse, frame alignment, then a continuous sample stream with FRAME marker and parity on DAC_D.
- Sits between the sample source and the DAC pin drivers, inside dac_top on the FPGA0_CLK domain.
- Pushes stream data with ready/valid, substitutes midscale on underflow, and stops only on frame boundaries.

Parameters:
- WORDS_PER_FRAME, 4, 16-bit words per DAC frame (>=2); FRAME marks word 0.
- SYNC_CYCLES, 16, cycles dac_sync is held high during startup (>=1).

Ports:
- clk  input  1  system clock (FPGA0_CLK domain).
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; high requests streaming, low requests stop.
- s_data  input  16  two's-complement sample word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  sequencer accepts s_data this cycle.
- dac_d  output  16  registered DAC data word.
- dac_frame  output  1  high for one cycle on word 0 of each frame.
- dac_sync  output  1  DAC sync strobe.
- dac_parity  output  1  even parity over dac_d, same cycle as dac_d.
- running  output  1  high while in RUN.
- underflow  output  1  sticky, set on any RUN cycle with s_valid=0.
- underflow_clr  input  1  clears underflow.

Behaviour:
- Reset, asynchronous: state=IDLE, word counter=0, sync counter=0. All outputs are 0, including dac_d=16'h0000 and underflow=0.
- All outputs are registered. s_ready and running decode the registered state.
- IDLE:
  - dac_d=0, frame=0, sync=0, s_ready=0.
  - enable=1 -> SYNC.
- SYNC:
  - dac_sync=1 for exactly SYNC_CYCLES cycles; dac_d=0.
  - When complete -> ALIGN.
  - enable=0 -> IDLE next cycle (abort).
- ALIGN:
  - Emits one frame of zero words (WORDS_PER_FRAME cycles), dac_frame=1 on word 0, s_ready=0.
  - When complete -> RUN with counter=0.
  - enable=0 -> IDLE immediately.
- RUN:
  - s_ready=1 and running=1 every cycle. Word counter increments modulo WORDS_PER_FRAME every cycle, regardless of s_valid.
  - Latency: a word accepted at cycle n (s_valid & s_ready) appears on dac_d at cycle n+1.
  - dac_frame at n+1 equals (counter==0 at n).
  - If s_valid=0 at cycle n, dac_d=16'h0000 at n+1 and underflow is set.
- Stop:
  - enable=0 in RUN: streaming continues until the word at counter WORDS_PER_FRAME-1 is accepted; the next state is IDLE. No partial frames.
  - If enable returns to 1 before the final word is accepted, the stop request is cancelled.
- Restart from IDLE always repeats the full SYNC and ALIGN sequence.
- Underflow:
  - Set and underflow_clr in the same cycle: set wins.
  - underflow_clr in any state clears underflow only when there is no simultaneous set.
- dac_parity = XOR of all 16 bits of the dac_d register, registered in the same cycle.
- Mid-operation reset: outputs go to zero asynchronously. Any in-flight word is dropped and no s_ready is issued until the next SYNC/ALIGN sequence completes.

Optional Feature:
- Macro: DAC_FRAME_SEQUENCER_PARITY_EN.
- Defined: dac_parity is computed as above.
- Undefined: the parity logic is omitted and dac_parity is tied to 0 in all states; all other behaviour is unchanged.

Test Plan (WORDS_PER_FRAME=4, SYNC_CYCLES=16):
- Startup: rst pulse, then enable=1 -> dac_sync high exactly 16 cycles, then 4 zero words with dac_frame on the first, then s_ready=1 and running=1.
- Streaming: s_valid=1 with data 16'h0001, 0002, 0003, ... -> dac_d shows the same sequence 1 cycle later. dac_frame is high on 0001, 0005, 0009. dac_parity=1 for 0001 and 0 for 0003 (macro defined).
- Underflow: drop s_valid for 1 cycle mid-frame -> dac_d=0000 on that slot, frame cadence unchanged, underflow=1 until underflow_clr. Clear and set in the same cycle -> underflow stays 1.
- Stop: enable=0 while the word at counter 1 is accepted -> words at counters 2 and 3 are still accepted, then state=IDLE and s_ready=0. Re-enable -> full 16-cycle sync is repeated.
- Abort/reset: enable=0 at cycle 5 of SYNC -> dac_sync=0 next cycle, IDLE. rst asserted mid-RUN -> all outputs 0 immediately, no s_ready until the next sync completes.
- Macro undefined: repeat the streaming test -> dac_parity=0 throughout, data and frame identical.
